// File: rtl/alpha_apply.sv
// alpha_apply: applies a per-block quantized alpha to a stream of xhat samples, pred = xmean + alpha*(xhat - xhatmean).
// Optional saturation of the result: define ALPHA_APPLY_CLAMP_EN (default build wraps modulo 2**DATA_WIDTH).
//
//   state      | meaning
//   -----------+------------------------------------------------------------
//   ST_LOAD    | waiting for the joined alpha/xmean/xhatmean handshake
//   ST_STREAM  | accepting the 2**BLOCK_SIZE_LOG xhat samples of the block
module alpha_apply #(
    parameter int DATA_WIDTH     = 16,
    parameter int BLOCK_SIZE_LOG = 8,
    parameter int ALPHA_WIDTH    = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   alpha_valid,
    output logic                   alpha_ready,
    input  logic [ALPHA_WIDTH-1:0] alpha_data,
    input  logic                   xmean_valid,
    output logic                   xmean_ready,
    input  logic [DATA_WIDTH-1:0]  xmean_data,
    input  logic                   xhatmean_valid,
    output logic                   xhatmean_ready,
    input  logic [DATA_WIDTH-1:0]  xhatmean_data,
    input  logic                   xhat_valid,
    output logic                   xhat_ready,
    input  logic [DATA_WIDTH-1:0]  xhat_data,
    output logic                   pred_valid,
    input  logic                   pred_ready,
    output logic [DATA_WIDTH-1:0]  pred_data
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ALPHA_WIDTH;
    localparam int BL = BLOCK_SIZE_LOG;
    localparam int PW = DW + AW + 2;
`ifdef ALPHA_APPLY_CLAMP_EN
    localparam int SW = PW + 1;
`else
    localparam int SW = DW;
`endif

    localparam logic [0:0] ST_LOAD   = 1'b0;
    localparam logic [0:0] ST_STREAM = 1'b1;

    localparam logic [BL-1:0]        CNT_LAST = '1;
    localparam logic signed [PW-1:0] RND_HALF = PW'(2 ** (AW - 2));

    logic [0:0]             state_q, state_d;
    logic [BL-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          alpha_q, alpha_d;
    logic [DW-1:0]          xmean_q, xmean_d;
    logic [DW-1:0]          xhatmean_q, xhatmean_d;

    logic                   s1_valid_q, s1_valid_d;
    logic signed [DW:0]     s1_diff_q, s1_diff_d;
    logic [AW-1:0]          s1_alpha_q, s1_alpha_d;
    logic [DW-1:0]          s1_xmean_q, s1_xmean_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [DW-1:0]          s2_pred_q, s2_pred_d;

    logic                   load_fire;
    logic                   xhat_fire;
    logic                   s1_adv;
    logic                   s2_adv;

    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   prod_rnd;
    logic signed [PW-1:0]   scaled;
    logic signed [SW-1:0]   sum;
    logic [DW-1:0]          pred_res;

    // Gated by rst so the readies read as zero for the whole reset window.
    assign load_fire      = !rst && (state_q == ST_LOAD) && alpha_valid && xmean_valid && xhatmean_valid;
    assign alpha_ready    = load_fire;
    assign xmean_ready    = load_fire;
    assign xhatmean_ready = load_fire;

    assign s2_adv     = !s2_valid_q || pred_ready;
    assign s1_adv     = !s1_valid_q || s2_adv;
    assign xhat_ready = (state_q == ST_STREAM) && s1_adv;
    assign xhat_fire  = xhat_valid && xhat_ready;

    assign pred_valid = s2_valid_q;
    assign pred_data  = s2_pred_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        alpha_d    = alpha_q;
        xmean_d    = xmean_q;
        xhatmean_d = xhatmean_q;
        case (state_q)
            ST_LOAD: begin
                if (load_fire) begin
                    alpha_d    = alpha_data;
                    xmean_d    = xmean_data;
                    xhatmean_d = xhatmean_data;
                    cnt_d      = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (xhat_fire) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        cnt_d = cnt_q + BL'(1);
                    end
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Stage 1 takes its own copy of alpha/xmean so a following LOAD cannot disturb it.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_diff_d  = s1_diff_q;
        s1_alpha_d = s1_alpha_q;
        s1_xmean_d = s1_xmean_q;
        if (s1_adv) begin
            s1_valid_d = xhat_fire;
            if (xhat_fire) begin
                s1_diff_d  = $signed({1'b0, xhat_data}) - $signed({1'b0, xhatmean_q});
                s1_alpha_d = alpha_q;
                s1_xmean_d = xmean_q;
            end
        end
    end

    always_comb begin
        prod     = PW'(s1_diff_q) * PW'($signed({1'b0, s1_alpha_q}));
        prod_rnd = prod + RND_HALF;
        scaled   = prod_rnd >>> (AW - 1);
        sum      = $signed(SW'(scaled) + SW'({1'b0, s1_xmean_q}));
`ifdef ALPHA_APPLY_CLAMP_EN
        if (sum[SW-1]) begin
            pred_res = '0;
        end else if (|sum[SW-2:DW]) begin
            pred_res = '1;
        end else begin
            pred_res = sum[DW-1:0];
        end
`else
        pred_res = sum;
`endif
    end

    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_pred_d  = s2_pred_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_pred_d = pred_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            alpha_q    <= '0;
            xmean_q    <= '0;
            xhatmean_q <= '0;
            s1_valid_q <= 1'b0;
            s1_diff_q  <= '0;
            s1_alpha_q <= '0;
            s1_xmean_q <= '0;
            s2_valid_q <= 1'b0;
            s2_pred_q  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alpha_q    <= alpha_d;
            xmean_q    <= xmean_d;
            xhatmean_q <= xhatmean_d;
            s1_valid_q <= s1_valid_d;
            s1_diff_q  <= s1_diff_d;
            s1_alpha_q <= s1_alpha_d;
            s1_xmean_q <= s1_xmean_d;
            s2_valid_q <= s2_valid_d;
            s2_pred_q  <= s2_pred_d;
        end
    end

endmodule

// File: tb/tb_alpha_apply.sv
// Bench for alpha_apply (BLOCK_SIZE_LOG=2); expected predictions come from an integer reference function.
// Expectations follow ALPHA_APPLY_CLAMP_EN in the same way as the design.
module tb_alpha_apply;

    localparam int DW = 16;
    localparam int AW = 10;
    localparam int BL = 2;
    localparam int BS = 4;

    typedef struct {
        int a;
        int xm;
        int xhm;
    } prm_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          alpha_valid = 1'b0, alpha_ready;
    logic [AW-1:0] alpha_data = '0;
    logic          xmean_valid = 1'b0, xmean_ready;
    logic [DW-1:0] xmean_data = '0;
    logic          xhatmean_valid = 1'b0, xhatmean_ready;
    logic [DW-1:0] xhatmean_data = '0;
    logic          xhat_valid = 1'b0, xhat_ready;
    logic [DW-1:0] xhat_data = '0;
    logic          pred_valid;
    logic          pred_ready = 1'b1;
    logic [DW-1:0] pred_data;

    alpha_apply #(.DATA_WIDTH(DW), .BLOCK_SIZE_LOG(BL), .ALPHA_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .alpha_valid(alpha_valid), .alpha_ready(alpha_ready), .alpha_data(alpha_data),
        .xmean_valid(xmean_valid), .xmean_ready(xmean_ready), .xmean_data(xmean_data),
        .xhatmean_valid(xhatmean_valid), .xhatmean_ready(xhatmean_ready), .xhatmean_data(xhatmean_data),
        .xhat_valid(xhat_valid), .xhat_ready(xhat_ready), .xhat_data(xhat_data),
        .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_data(pred_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    prm_t pq[$];
    int   xq[$];

    int   got_q[$];
    int   got_cyc[$];
    int   acc_cyc[$];
    int   cyc = 0;
    int   load_cnt = 0, xhat_cnt = 0;
    int   blk_err = 0, stall_err = 0, ready_err = 0, to_err = 0;
    int   mon_cnt = 0;
    bit   mon_fresh = 1'b1;
    bit   prev_stall = 1'b0;
    int   prev_data = 0;

    // Observes the interface half a cycle away from the active edge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            mon_fresh  = 1'b1;
            mon_cnt    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (pred_valid !== 1'b1 || int'(pred_data) != prev_data)) stall_err++;
            prev_stall = pred_valid && !pred_ready;
            prev_data  = int'(pred_data);
            if (pred_valid && pred_ready) begin
                got_q.push_back(int'(pred_data));
                got_cyc.push_back(cyc);
            end
            if (alpha_ready !== xmean_ready || alpha_ready !== xhatmean_ready) ready_err++;
            if (alpha_ready && xhat_ready) ready_err++;
            if (alpha_ready && !(alpha_valid && xmean_valid && xhatmean_valid)) ready_err++;
            if (alpha_valid && xmean_valid && xhatmean_valid && alpha_ready) begin
                load_cnt++;
                if (!mon_fresh && mon_cnt != BS) blk_err++;
                mon_fresh = 1'b0;
                mon_cnt   = 0;
            end
            if (xhat_valid && xhat_ready) begin
                xhat_cnt++;
                acc_cyc.push_back(cyc);
                if (mon_fresh) blk_err++;
                mon_cnt++;
                if (mon_cnt > BS) blk_err++;
            end
        end
    end

    function automatic int ref_pred(input int a, input int xm, input int xhm, input int xh);
        longint d, p, r, s;
        d = longint'(xh) - longint'(xhm);
        p = d * longint'(a);
        r = (p + 256) >>> 9;
        s = longint'(xm) + r;
`ifdef ALPHA_APPLY_CLAMP_EN
        if (s < 0) s = 0;
        if (s > 65535) s = 65535;
        return int'(s);
`else
        return int'(((s % 65536) + 65536) % 65536);
`endif
    endfunction

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
        acc_cyc.delete();
        pq.delete();
        xq.delete();
        load_cnt  = 0;
        xhat_cnt  = 0;
        blk_err   = 0;
        stall_err = 0;
        ready_err = 0;
        to_err    = 0;
    endtask

    task automatic push_blk(input int a, input int xm, input int xhm);
        prm_t p;
        p.a = a;
        p.xm = xm;
        p.xhm = xhm;
        pq.push_back(p);
    endtask

    task automatic run(input int n_out, input int pr_pct, input int xv_pct, input int max_cyc);
        int c;
        bit lf, xf;
        c  = 0;
        xf = 1'b1;
        while (c < max_cyc && (pq.size() != 0 || xq.size() != 0 || got_q.size() < n_out)) begin
            alpha_valid    = (pq.size() != 0);
            xmean_valid    = alpha_valid;
            xhatmean_valid = alpha_valid;
            if (pq.size() != 0) begin
                alpha_data    = AW'(pq[0].a);
                xmean_data    = DW'(pq[0].xm);
                xhatmean_data = DW'(pq[0].xhm);
            end
            if (xq.size() == 0) xhat_valid = 1'b0;
            else if (xf || !xhat_valid) xhat_valid = ($urandom_range(99) < xv_pct);
            if (xq.size() != 0) xhat_data = DW'(xq[0]);
            pred_ready = ($urandom_range(99) < pr_pct);
            @(negedge clk);
            lf = alpha_valid && alpha_ready;
            xf = xhat_valid && xhat_ready;
            @(posedge clk);
            #1;
            if (lf) void'(pq.pop_front());
            if (xf) void'(xq.pop_front());
            c++;
        end
        if (c >= max_cyc) to_err++;
        alpha_valid    = 1'b0;
        xmean_valid    = 1'b0;
        xhatmean_valid = 1'b0;
        xhat_valid     = 1'b0;
        pred_ready     = 1'b1;
    endtask

    task automatic test_reset();
        alpha_valid = 1'b1; xmean_valid = 1'b1; xhatmean_valid = 1'b1; xhat_valid = 1'b1;
        #12;
        checks++;
        if (pred_valid !== 1'b0 || pred_data !== '0) begin
            failures++;
            $display("FAIL reset_pred: valid=%b data=%0d required valid=0 data=0", pred_valid, pred_data);
        end
        checks++;
        if ({alpha_ready, xmean_ready, xhatmean_ready, xhat_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready: readies=%b required 0000",
                     {alpha_ready, xmean_ready, xhatmean_ready, xhat_ready});
        end
        alpha_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0; xhat_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        int exp_v[4] = '{512, 514, 516, 518};
        int g;
        clear_mon();
        push_blk(512, 640, 384);
        xq = '{256, 258, 260, 262};
        run(4, 100, 100, 200);
        checks++;
        if (to_err != 0 || got_q.size() != 4) begin
            failures++;
            $display("FAIL basic_count: got %0d outputs timeout=%0d required 4 outputs", got_q.size(), to_err);
        end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : -1;
            checks++;
            if (g != exp_v[i]) begin
                failures++;
                $display("FAIL basic_pred[%0d]: got %0d required %0d", i, g, exp_v[i]);
            end
            g = (i < got_cyc.size() && i < acc_cyc.size()) ? got_cyc[i] - acc_cyc[i] : -1;
            checks++;
            if (g != 2) begin
                failures++;
                $display("FAIL basic_latency[%0d]: got %0d cycles required 2", i, g);
            end
        end
    endtask

    task automatic test_rounding();
        int exp_v[4] = '{1002, 1001, 1000, 999};
        int g;
        clear_mon();
        push_blk(256, 1000, 384);
        xq = '{387, 385, 383, 381};
        run(4, 100, 100, 200);
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : -1;
            checks++;
            if (g != exp_v[i]) begin
                failures++;
                $display("FAIL round_pred[%0d]: got %0d required %0d", i, g, exp_v[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int g;
`ifdef ALPHA_APPLY_CLAMP_EN
        int exp_ovf = 65535;
        int exp_unf = 0;
`else
        int exp_ovf = 64870;
        int exp_unf = 65436;
`endif
        clear_mon();
        push_blk(1023, 65000, 0);
        push_blk(512, 0, 100);
        xq = '{65535, 65535, 65535, 65535, 0, 0, 0, 0};
        run(8, 100, 100, 200);
        for (int i = 0; i < 8; i++) begin
            g = (i < got_q.size()) ? got_q[i] : -1;
            checks++;
            if (g != ((i < 4) ? exp_ovf : exp_unf)) begin
                failures++;
                $display("FAIL ovf_pred[%0d]: got %0d required %0d", i, g, (i < 4) ? exp_ovf : exp_unf);
            end
        end
    endtask

    task automatic test_backpressure();
        prm_t blk[8];
        int   xs[32];
        int   g, e, bad;
        clear_mon();
        for (int b = 0; b < 8; b++) begin
            blk[b].a   = int'($urandom_range(1023));
            blk[b].xm  = int'($urandom_range(65535));
            blk[b].xhm = int'($urandom_range(65535));
            pq.push_back(blk[b]);
        end
        for (int i = 0; i < 32; i++) begin
            xs[i] = int'($urandom_range(65535));
            xq.push_back(xs[i]);
        end
        run(32, 50, 70, 2000);
        bad = 0;
        for (int i = 0; i < 32; i++) begin
            g = (i < got_q.size()) ? got_q[i] : -1;
            e = ref_pred(blk[i / 4].a, blk[i / 4].xm, blk[i / 4].xhm, xs[i]);
            checks++;
            if (g != e) begin
                failures++;
                bad++;
                if (bad < 5) $display("FAIL bp_pred[%0d]: got %0d required %0d", i, g, e);
            end
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL bp_stall_stable: %0d violations required 0", stall_err);
        end
        checks++;
        if (load_cnt != 8 || xhat_cnt != 32 || blk_err != 0 || to_err != 0) begin
            failures++;
            $display("FAIL bp_counts: loads=%0d xhat=%0d blk_err=%0d timeout=%0d required 8 32 0 0",
                     load_cnt, xhat_cnt, blk_err, to_err);
        end
    endtask

    task automatic test_block_boundary();
        int a_v[3] = '{100, 600, 1000};
        int xm_v[3], xhm_v[3], xs[12];
        int g, e;
        clear_mon();
        for (int b = 0; b < 3; b++) begin
            xm_v[b]  = int'($urandom_range(20000, 40000));
            xhm_v[b] = int'($urandom_range(20000, 40000));
            push_blk(a_v[b], xm_v[b], xhm_v[b]);
        end
        for (int i = 0; i < 12; i++) begin
            xs[i] = int'($urandom_range(10000, 50000));
            xq.push_back(xs[i]);
        end
        run(12, 50, 100, 500);
        for (int i = 0; i < 12; i++) begin
            g = (i < got_q.size()) ? got_q[i] : -1;
            e = ref_pred(a_v[i / 4], xm_v[i / 4], xhm_v[i / 4], xs[i]);
            checks++;
            if (g != e) begin
                failures++;
                $display("FAIL bb_pred[%0d]: got %0d required %0d", i, g, e);
            end
        end
        checks++;
        if (load_cnt != 3 || blk_err != 0 || ready_err != 0 || stall_err != 0) begin
            failures++;
            $display("FAIL bb_handshake: loads=%0d blk_err=%0d ready_err=%0d stall_err=%0d required 3 0 0 0",
                     load_cnt, blk_err, ready_err, stall_err);
        end
    endtask

    task automatic test_reset_mid_block();
        int exp_v[4] = '{11, 12, 13, 14};
        int g;
        clear_mon();
        push_blk(700, 5000, 3000);
        xq = '{4000, 4100};
        run(0, 0, 100, 50);
        pred_ready = 1'b0;
        alpha_valid = 1'b1; xmean_valid = 1'b1; xhatmean_valid = 1'b1; xhat_valid = 1'b1;
        rst = 1'b1;
        #1;
        checks++;
        if (pred_valid !== 1'b0 || pred_data !== '0 ||
            {alpha_ready, xmean_ready, xhatmean_ready, xhat_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL midrst_outputs: valid=%b data=%0d readies=%b required 0 0 0000", pred_valid,
                     pred_data, {alpha_ready, xmean_ready, xhatmean_ready, xhat_ready});
        end
        alpha_valid = 1'b0; xmean_valid = 1'b0; xhatmean_valid = 1'b0; xhat_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_mon();
        push_blk(512, 10, 0);
        xq = '{1, 2, 3, 4};
        run(4, 100, 100, 100);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 4 || to_err != 0) begin
            failures++;
            $display("FAIL midrst_count: got %0d outputs timeout=%0d required 4", got_q.size(), to_err);
        end
        for (int i = 0; i < 4; i++) begin
            g = (i < got_q.size()) ? got_q[i] : -1;
            checks++;
            if (g != exp_v[i]) begin
                failures++;
                $display("FAIL midrst_pred[%0d]: got %0d required %0d", i, g, exp_v[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_overflow();
        test_backpressure();
        test_block_boundary();
        test_reset_mid_block();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
